// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Serial frame receiver. Hunts for SYNC_WORD on a strobed bit
//               stream, deserializes the next DATA_W bits MSB-first and
//               queues each byte in a 2-entry FIFO behind valid/ready.
//               Define PARITY_CHECK_EN to append and check an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sdin,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sync_lock,
    output logic              frame_err,
    output logic              overflow
);

    localparam int                 c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_HUNT   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] c_ST_PARITY = 2'd2;
`endif

    localparam logic [1:0] c_FIFO_EMPTY = 2'd0;
    localparam logic [1:0] c_FIFO_FULL  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    // The oldest sync bit never takes part in the match, so only 7 are kept.
    logic [6:0]         r_sync;
    logic [DATA_W-1:0]  r_data;
    logic [c_CNT_W-1:0] r_bit_cnt;

    logic [7:0]         w_sync_shift;
    logic               w_sync_hit;
    logic [DATA_W-1:0]  w_data_shift;
    logic               w_last_bit;

    logic               w_push_req;
    logic [DATA_W-1:0]  w_push_data;
`ifdef PARITY_CHECK_EN
    logic               w_par_fail;
    logic               r_frame_err;
`else
    logic               w_unused_data_msb;
`endif

    logic [DATA_W-1:0]  r_head;
    logic [DATA_W-1:0]  r_tail;
    logic [1:0]         r_count;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               r_overflow;

    assign w_sync_shift = {r_sync, sdin};
    assign w_sync_hit   = (w_sync_shift == SYNC_WORD);
    assign w_data_shift = {r_data[DATA_W-2:0], sdin};
    assign w_last_bit   = (r_bit_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (bit_en) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_sync_hit) begin
                        w_state_next = c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
                        w_state_next = c_ST_PARITY;
`else
                        w_state_next = c_ST_HUNT;
`endif
                    end
                end
                default: begin
                    w_state_next = c_ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        sync_lock  = (r_state != c_ST_HUNT);
        w_push_req = 1'b0;
`ifdef PARITY_CHECK_EN
        w_push_data = r_data;
        w_par_fail  = 1'b0;
`else
        w_push_data = w_data_shift;
`endif
        if (bit_en) begin
            case (r_state)
`ifdef PARITY_CHECK_EN
                c_ST_PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (^{r_data, sdin}) begin
                        w_par_fail = 1'b1;
                    end else begin
                        w_push_req = 1'b1;
                    end
                end
`else
                c_ST_DATA: begin
                    if (w_last_bit) begin
                        w_push_req = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serial shift registers and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_data    <= '0;
            r_bit_cnt <= '0;
        end else if (bit_en) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_sync_hit) begin
                        // Clearing here forces a completely fresh sync word per frame.
                        r_sync    <= '0;
                        r_data    <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_sync <= w_sync_shift[6:0];
                    end
                end
                c_ST_DATA: begin
                    r_data    <= w_data_shift;
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + c_CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO (head/tail registers)
    // ------------------------------------------------------------------
    assign out_valid = (r_count != c_FIFO_EMPTY);
    assign out_data  = r_head;
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_push_req && ((r_count != c_FIFO_FULL) || w_pop);
    assign w_drop    = w_push_req && (r_count == c_FIFO_FULL) && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= c_FIFO_EMPTY;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == c_FIFO_EMPTY) begin
                        r_head <= w_push_data;
                    end else begin
                        r_tail <= w_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Draining the last entry leaves the head untouched.
                    if (r_count == c_FIFO_FULL) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == c_FIFO_FULL) begin
                        r_head <= r_tail;
                        r_tail <= w_push_data;
                    end else begin
                        r_head <= w_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
        end
    end
    assign overflow = r_overflow;

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_par_fail;
        end
    end
    assign frame_err = r_frame_err;
`else
    assign frame_err         = 1'b0;
    assign w_unused_data_msb = r_data[DATA_W-1];
`endif

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 8-bit load/shift-left register stage.
- Samples that stage's MSB as a serial bitstream, one bit per enabled clock.
- Hunts for a sync word, deserializes the following data byte MSB-first and checks it.
- Buffers received bytes in a 2-entry FIFO behind a valid/ready output handshake.

Parameters:
- SYNC_WORD, 8'hA5, pattern that must be seen before each data byte.
- DATA_W, 8, data byte width; the bit counter is sized to DATA_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- bit_en  input  1  sample strobe; sdin is consumed only on clocks where bit_en=1
- sdin  input  1  serial data (upstream shift register MSB)
- out_data  output  DATA_W  FIFO head byte
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when out_valid&&out_ready
- sync_lock  output  1  high while the FSM is not in HUNT
- frame_err  output  1  one-cycle pulse: parity mismatch, frame discarded
- overflow  output  1  one-cycle pulse: frame completed while FIFO full, frame discarded

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock and reset:
  - All state updates on the rising edge of clk.
  - rst=1 at any edge, including mid-frame: FSM=HUNT, sync shift reg=0, bit count=0, FIFO emptied.
  - Reset values: out_data=0, out_valid=0, sync_lock=0, frame_err=0, overflow=0.
- Bit sampling: only clocks with bit_en=1 advance the FSM or shift registers. bit_en=0 holds all serial state; the FIFO pop still operates.
- HUNT:
  - Sync reg shifts left with sdin entering the LSB.
  - If the updated value {sync[6:0],sdin} == SYNC_WORD, go to DATA next cycle with bit count=0 and the data reg cleared.
  - Sync reg is cleared on leaving HUNT, so no overlap reuse.
- DATA:
  - Data reg shifts left with sdin entering the LSB; bit count increments.
  - On the DATA_W-th bit, go to PARITY (macro defined) or complete the frame (macro undefined).
- PARITY: consume one bit, check it, then complete or discard the frame.
- Frame completion:
  - Push the byte into the FIFO and return to HUNT.
  - If the FIFO is full and no pop occurs in the same cycle: drop the byte, pulse overflow for 1 cycle, return to HUNT.
- Every frame requires a fresh sync word.
- Latency: a pushed byte appears on out_data with out_valid=1 on the clock after the final frame bit is sampled.
- FIFO:
  - 2 entries, in-order; out_data = head entry.
  - Pop when out_valid&&out_ready.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while holding 1 entry: count stays 1 and the head advances to the new byte.
  - Empty: out_valid=0 and out_data holds its last value (0 after reset).
- sync_lock: combinational from state (state!=HUNT); rises the cycle after the sync match.
- Pulses: frame_err and overflow are registered, high for exactly one cycle, mutually exclusive per frame.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - A PARITY state follows the data bits and consumes one even-parity bit.
  - Valid frame: XOR of the data bits and the parity bit = 0 → push.
  - Otherwise: discard, pulse frame_err, return to HUNT.
  - Frame length is 8+DATA_W+1 enabled bits.
- Undefined: no PARITY state, frame_err tied to 0, frame length is 8+DATA_W enabled bits.

Test Plan:
- Reset, then bit_en=1 with sdin stream 10100101 + 00111100 (+ parity 0 if macro defined), out_ready=1 → sync_lock high the cycle after the 8th bit; out_valid=1 with out_data=8'h3C one cycle after the last bit; popped the same cycle.
- Noise 0110 followed by A5 + 8'hFF (+ parity 0), with bit_en toggled 1/0 every cycle → byte 8'hFF received; each gap cycle holds state.
- out_ready=0, three back-to-back frames 8'h11, 8'h22, 8'h33 → FIFO holds 11, 22; overflow pulses once on the third frame. Raise out_ready → 11 then 22 are output, then out_valid=0.
- FIFO full (11, 22), third frame 8'h33 completes in the same cycle out_ready=1 → no overflow; sequence output is 11, 22, 33.
- PARITY_CHECK_EN defined: A5 + 8'h01 + parity 0 → frame_err pulse, out_valid stays 0, sync_lock falls. Then A5 + 8'h01 + parity 1 → 8'h01 delivered.
- Assert rst after 4 data bits → sync_lock=0 and FIFO empty next cycle. A following full frame A5 + 8'h5A is received correctly, with no stale bits.
